rtc_hms_counter: RTL

Parametrised real-time clock core: divides the system clock down to a configurable tick rate and keeps seconds, minutes and hours. Supports 12/24-hour mode, synchronous time load with range checking, a start/stop run control, and an hh:mm alarm. It is the successor to the fixed 1 Hz seconds/minutes counter and feeds display drivers and event logic on the board.

---
 rtl/rtc_pkg.sv | 32 +++
 rtl/rtc_tick_gen.sv | 31 +++
 rtl/rtc_hms_counter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared limits, field widths and load validation
// for the real-time clock core.
package rtc_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MAX = 12;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    // True when a load tuple is a legal time for the given mode.
    function automatic logic load_ok(
        input logic [HR_W-1:0]  hh,
        input logic [MIN_W-1:0] mm,
        input logic [SEC_W-1:0] ss,
        input logic             mode_24h
    );
        logic ok;
        ok = (ss <= SEC_W'(SEC_MAX)) && (mm <= MIN_W'(MIN_MAX));
        if (mode_24h) begin
            ok = ok && (hh <= HR_W'(HR24_MAX));
        end else begin
            ok = ok && (hh >= HR_W'(1))
                    && (hh <= HR_W'(HR12_MAX));
        end
        return ok;
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: run-gated prescaler. tick marks the edge on
// which the count wraps from DIV-1 to 0 with start high.
module rtc_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count while running, freeze while stopped, clear on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = start && (cnt == LAST);

endmodule

// File: rtl/rtc_hms_counter.sv
// rtc_hms_counter: hh:mm:ss time keeper with 12/24h mode,
// checked synchronous load and an hh:mm alarm.
module rtc_hms_counter
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int MODE_24H    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic [HR_W-1:0]  load_hh,
    input  logic [MIN_W-1:0] load_mm,
    input  logic [SEC_W-1:0] load_ss,
    input  logic             load_pm,
    input  logic             alarm_en,
    input  logic [HR_W-1:0]  alarm_hh,
    input  logic [MIN_W-1:0] alarm_mm,
    input  logic             alarm_pm,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HR_W-1:0]  hours,
    output logic             pm,
    output logic             sec_tick,
    output logic             min_tick,
    output logic             hour_tick,
    output logic             alarm,
    output logic             load_err
);

    localparam int  DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam bit  IS24  = (MODE_24H != 0);
    localparam logic [HR_W-1:0] HR_RST =
        IS24 ? '0 : HR_W'(HR12_MAX);

    logic             tick;
    logic             adv;
    logic             load_valid;
    logic             sec_wrap;
    logic             min_wrap;
    logic [SEC_W-1:0] sec_n;
    logic [MIN_W-1:0] min_n;
    logic [HR_W-1:0]  hr_n;
    logic             pm_n;
    logic             alarm_hit;

    assign load_valid = load_ok(load_hh, load_mm, load_ss, IS24);

    // A load in the same cycle swallows the advance.
    assign adv = tick && !load;

    rtc_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .clr   (load && load_valid),
        .tick  (tick)
    );

    // Next time value for one advance, with mode-dependent hour roll.
    always_comb begin
        sec_wrap = (seconds == SEC_W'(SEC_MAX));
        min_wrap = (minutes == MIN_W'(MIN_MAX));
        sec_n    = sec_wrap ? '0 : seconds + 1'b1;
        min_n    = minutes;
        hr_n     = hours;
        pm_n     = pm;
        if (sec_wrap) begin
            min_n = min_wrap ? '0 : minutes + 1'b1;
        end
        if (sec_wrap && min_wrap) begin
            if (IS24) begin
                hr_n = (hours == HR_W'(HR24_MAX)) ? '0
                                                  : hours + 1'b1;
            end else if (hours == HR_W'(HR12_MAX)) begin
                hr_n = HR_W'(1);
            end else if (hours == HR_W'(HR12_MAX - 1)) begin
                hr_n = HR_W'(HR12_MAX);
                pm_n = ~pm;
            end else begin
                hr_n = hours + 1'b1;
            end
        end
    end

    // Alarm fires only on the advance that lands on :00.
    always_comb begin
        alarm_hit = alarm_en && sec_wrap
                 && (hr_n == alarm_hh)
                 && (min_n == alarm_mm)
                 && (IS24 || (pm_n == alarm_pm));
    end

    // Time registers: valid load first, then advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seconds <= '0;
            minutes <= '0;
            hours   <= HR_RST;
            pm      <= 1'b0;
        end else if (load) begin
            if (load_valid) begin
                seconds <= load_ss;
                minutes <= load_mm;
                hours   <= load_hh;
                pm      <= IS24 ? 1'b0 : load_pm;
            end
        end else if (adv) begin
            seconds <= sec_n;
            minutes <= min_n;
            hours   <= hr_n;
            pm      <= IS24 ? 1'b0 : pm_n;
        end
    end

    // One-cycle event pulses aligned with the new counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_tick  <= 1'b0;
            min_tick  <= 1'b0;
            hour_tick <= 1'b0;
            alarm     <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_tick  <= adv;
            min_tick  <= adv && sec_wrap;
            hour_tick <= adv && sec_wrap && min_wrap;
            alarm     <= adv && alarm_hit;
            load_err  <= load && !load_valid;
        end
    end

endmodule
